// File: rtl/orange_centroid_tracker.sv
// Per-column-bin orange pixel histogram with dominant-bin steering output.
// Ports: clk, rst_n (sync, active-low), pixel_valid, is_orange, vsync (active-low)
//   in; direction, detected, max_count, frame_valid out.
module orange_centroid_tracker #(
  parameter int H_ACTIVE   = 320,
  parameter int N_BINS     = 5,
  parameter int CNT_W      = 17,
  parameter int MIN_PIXELS = 200,
  parameter int PERSIST    = 2,
  parameter int DIR_W      = $clog2(N_BINS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pixel_valid,
  input  logic             is_orange,
  input  logic             vsync,
  output logic [DIR_W-1:0] direction,
  output logic             detected,
  output logic [CNT_W-1:0] max_count,
  output logic             frame_valid
);

  localparam int BIN_W = H_ACTIVE / N_BINS;
  localparam int COL_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int STR_W = $clog2(PERSIST + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_PIXELS);
  localparam logic [DIR_W-1:0] DIR_RST  = DIR_W'(N_BINS / 2);
  localparam logic [DIR_W-1:0] LAST_BIN = DIR_W'(N_BINS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(BIN_W - 1);
  localparam logic [STR_W-1:0] STR_FULL = STR_W'(PERSIST);

  typedef enum logic [1:0] {
    ACCUM,
    SCAN,
    DECIDE
  } state_e;

  state_e           state_q, state_d;
  logic             pv_q, pv_d;
  logic             vs_q, vs_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [DIR_W-1:0] bin_q, bin_d;
  logic [CNT_W-1:0] cnt_q [N_BINS];
  logic [CNT_W-1:0] cnt_d [N_BINS];
  logic [DIR_W-1:0] scan_q, scan_d;
  logic [CNT_W-1:0] max_q, max_d;
  logic [DIR_W-1:0] arg_q, arg_d;
  logic             cand_hit_q, cand_hit_d;
  logic [DIR_W-1:0] cand_bin_q, cand_bin_d;
  logic [STR_W-1:0] streak_q, streak_d;
  logic [DIR_W-1:0] dir_q, dir_d;
  logic             det_q, det_d;
  logic [CNT_W-1:0] maxc_q, maxc_d;
  logic             fv_q, fv_d;

  logic             hit;
  logic             same;
  logic [STR_W-1:0] streak_nx;

  always_comb begin
    state_d    = state_q;
    pv_d       = pixel_valid;
    vs_d       = vsync;
    col_d      = col_q;
    bin_d      = bin_q;
    cnt_d      = cnt_q;
    scan_d     = scan_q;
    max_d      = max_q;
    arg_d      = arg_q;
    cand_hit_d = cand_hit_q;
    cand_bin_d = cand_bin_q;
    streak_d   = streak_q;
    dir_d      = dir_q;
    det_d      = det_q;
    maxc_d     = maxc_q;
    fv_d       = 1'b0;
    hit        = 1'b0;
    same       = 1'b0;
    streak_nx  = streak_q;

    // Column position; the last bin keeps absorbing columns.
    if (pixel_valid) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (bin_q != LAST_BIN) begin
          bin_d = bin_q + DIR_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end else if (pv_q) begin
      col_d = '0;
      bin_d = '0;
    end

    unique case (state_q)
      ACCUM: begin
        if (pixel_valid && is_orange &&
            cnt_q[bin_q] != CNT_MAX) begin
          cnt_d[bin_q] = cnt_q[bin_q] + CNT_W'(1);
        end
        if (vs_q && !vsync) begin
          state_d = SCAN;
          scan_d  = '0;
          max_d   = '0;
          arg_d   = '0;
        end
      end
      SCAN: begin
        // Strict compare keeps the lowest index on ties.
        if (cnt_q[scan_q] > max_q) begin
          max_d = cnt_q[scan_q];
          arg_d = scan_q;
        end
        if (scan_q == LAST_BIN) begin
          state_d = DECIDE;
        end else begin
          scan_d = scan_q + DIR_W'(1);
        end
      end
      DECIDE: begin
        hit  = (max_q >= MIN_C);
        same = (hit == cand_hit_q) &&
               (!hit || arg_q == cand_bin_q);
        if (same) begin
          streak_nx = (streak_q == STR_FULL) ?
                      streak_q : streak_q + STR_W'(1);
        end else begin
          cand_hit_d = hit;
          cand_bin_d = arg_q;
          streak_nx  = STR_W'(1);
        end
        streak_d = streak_nx;
        if (streak_nx == STR_FULL) begin
          det_d = hit;
          if (hit) begin
            dir_d = arg_q;
          end
        end
        maxc_d = max_q;
        fv_d   = 1'b1;
        for (int i = 0; i < N_BINS; i++) begin
          cnt_d[i] = '0;
        end
        state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      pv_q       <= 1'b0;
      vs_q       <= 1'b0;
      col_q      <= '0;
      bin_q      <= '0;
      for (int i = 0; i < N_BINS; i++) begin
        cnt_q[i] <= '0;
      end
      scan_q     <= '0;
      max_q      <= '0;
      arg_q      <= '0;
      cand_hit_q <= 1'b0;
      cand_bin_q <= '0;
      streak_q   <= '0;
      dir_q      <= DIR_RST;
      det_q      <= 1'b0;
      maxc_q     <= '0;
      fv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      pv_q       <= pv_d;
      vs_q       <= vs_d;
      col_q      <= col_d;
      bin_q      <= bin_d;
      cnt_q      <= cnt_d;
      scan_q     <= scan_d;
      max_q      <= max_d;
      arg_q      <= arg_d;
      cand_hit_q <= cand_hit_d;
      cand_bin_q <= cand_bin_d;
      streak_q   <= streak_d;
      dir_q      <= dir_d;
      det_q      <= det_d;
      maxc_q     <= maxc_d;
      fv_q       <= fv_d;
    end
  end

  assign direction   = dir_q;
  assign detected    = det_q;
  assign max_count   = maxc_q;
  assign frame_valid = fv_q;

endmodule

// File: tb/tb_orange_centroid_tracker.sv
// Scoreboard bench for orange_centroid_tracker: default instance plus an
// 8-bit-counter instance used for saturation.
module tb_orange_centroid_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pixel_valid = 1'b0;
  logic        is_orange = 1'b0;
  logic        vsync = 1'b1;
  logic [2:0]  direction, s_direction;
  logic        detected, s_detected;
  logic [16:0] max_count;
  logic [7:0]  s_max_count;
  logic        frame_valid, s_frame_valid;

  always #5 clk = ~clk;

  orange_centroid_tracker u_dut (
    .clk(clk), .rst_n(rst_n),
    .pixel_valid(pixel_valid), .is_orange(is_orange),
    .vsync(vsync), .direction(direction),
    .detected(detected), .max_count(max_count),
    .frame_valid(frame_valid)
  );

  orange_centroid_tracker #(.CNT_W(8)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .pixel_valid(pixel_valid), .is_orange(is_orange),
    .vsync(vsync), .direction(s_direction),
    .detected(s_detected), .max_count(s_max_count),
    .frame_valid(s_frame_valid)
  );

  typedef struct {
    int mc;
    int det;
    int dir;
  } exp_t;

  exp_t q_m[$];
  exp_t q_s[$];

  int n_chk = 0;
  int n_pass = 0;

  int bincnt[5];
  int cmax[2] = '{131071, 255};
  int m_hit[2], m_bin[2], m_str[2];
  int m_det[2], m_dir[2];

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_hit[k] = 0; m_bin[k] = 0; m_str[k] = 0;
      m_det[k] = 0; m_dir[k] = 2;
    end
    for (int b = 0; b < 5; b++) bincnt[b] = 0;
  endtask

  task automatic model_frame(input int k, output exp_t e);
    int mx, arg, c, hit;
    mx = 0; arg = 0;
    for (int b = 0; b < 5; b++) begin
      c = (bincnt[b] > cmax[k]) ? cmax[k] : bincnt[b];
      if (c > mx) begin mx = c; arg = b; end
    end
    hit = (mx >= 200) ? 1 : 0;
    if (hit == m_hit[k] && (hit == 0 || arg == m_bin[k])) begin
      if (m_str[k] < 2) m_str[k]++;
    end else begin
      m_hit[k] = hit; m_bin[k] = arg; m_str[k] = 1;
    end
    if (m_str[k] == 2) begin
      m_det[k] = hit;
      if (hit == 1) m_dir[k] = arg;
    end
    e.mc = mx; e.det = m_det[k]; e.dir = m_dir[k];
  endtask

  function automatic int bin_of(int c);
    return (c / 64 > 4) ? 4 : c / 64;
  endfunction

  task automatic drive_line(int len, int lo0, int hi0,
                            int lo1, int hi1);
    logic o;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      o = (c >= lo0 && c <= hi0) || (c >= lo1 && c <= hi1);
      pixel_valid = 1'b1;
      is_orange = o;
      if (o) bincnt[bin_of(c)]++;
    end
    @(negedge clk);
    pixel_valid = 1'b0;
    is_orange = 1'b0;
  endtask

  task automatic end_frame();
    exp_t e;
    int n;
    model_frame(0, e); q_m.push_back(e);
    model_frame(1, e); q_s.push_back(e);
    @(negedge clk);
    vsync = 1'b0;
    n = 21;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (frame_valid) begin n = i; break; end
    end
    chk("fv_latency", n, 7);
    @(posedge clk); #1;
    chk("fv_width", frame_valid, 0);
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    for (int b = 0; b < 5; b++) bincnt[b] = 0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("rst_dir", direction, 2);
    chk("rst_det", detected, 0);
    chk("rst_mc", max_count, 0);
    chk("rst_fv", frame_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (frame_valid) begin
        if (q_m.size() == 0) chk("m_unexpected", 1, 0);
        else begin
          e = q_m.pop_front();
          chk("m_max_count", max_count, e.mc);
          chk("m_detected", detected, e.det);
          chk("m_direction", direction, e.dir);
        end
      end
      if (s_frame_valid) begin
        if (q_s.size() == 0) chk("s_unexpected", 1, 0);
        else begin
          e = q_s.pop_front();
          chk("s_max_count", s_max_count, e.mc);
          chk("s_detected", s_detected, e.det);
          chk("s_direction", s_direction, e.dir);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=%0d exp=%0d", n_chk, -1);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("init_dir", direction, 2);
    chk("init_det", detected, 0);
    chk("init_mc", max_count, 0);
    chk("init_fv", frame_valid, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Bin 2 target, two frames.
    for (int f = 0; f < 2; f++) begin
      for (int l = 0; l < 7; l++) drive_line(320, 140, 179, -1, -1);
      drive_line(320, 140, 159, -1, -1);
      end_frame();
      chk("t1_mc", max_count, 300);
      chk("t1_det", detected, f);
      chk("t1_dir", direction, 2);
    end

    // Below threshold in bin 4: drop detection, hold direction.
    for (int f = 0; f < 2; f++) begin
      for (int l = 0; l < 3; l++) drive_line(320, 256, 305, -1, -1);
      end_frame();
    end
    chk("t3_mc", max_count, 150);
    chk("t3_det", detected, 0);
    chk("t3_dir", direction, 2);

    // Tie between bin 0 and bin 4.
    for (int f = 0; f < 2; f++) begin
      for (int l = 0; l < 5; l++) drive_line(320, 0, 49, 270, 319);
      end_frame();
    end
    chk("t2_mc", max_count, 250);
    chk("t2_det", detected, 1);
    chk("t2_dir", direction, 0);

    // Alternating bins never persist.
    pulse_reset();
    for (int f = 0; f < 4; f++) begin
      for (int l = 0; l < 5; l++) begin
        if (f % 2 == 0) drive_line(320, 64, 123, -1, -1);
        else drive_line(320, 192, 251, -1, -1);
      end
      end_frame();
      chk("t4_det", detected, 0);
      chk("t4_dir", direction, 2);
    end

    // Short lines restart the column count.
    drive_line(100, -1, -1, -1, -1);
    drive_line(320, 0, 0, -1, -1);
    end_frame();
    chk("t5_one", max_count, 1);
    for (int f = 0; f < 2; f++) begin
      for (int l = 0; l < 4; l++) begin
        drive_line(100, -1, -1, -1, -1);
        drive_line(320, 0, 63, -1, -1);
      end
      end_frame();
    end
    chk("t5_short_det", detected, 1);
    chk("t5_short_dir", direction, 0);

    // Saturation on the 8-bit instance.
    for (int f = 0; f < 2; f++) begin
      for (int l = 0; l < 5; l++) drive_line(320, 256, 319, -1, -1);
      end_frame();
      chk("t5_sat", s_max_count, 255);
      chk("t5_nosat", max_count, 320);
    end
    chk("t5_det", detected, 1);
    chk("t5_dir", direction, 4);

    // Mid-frame reset discards earlier pixels.
    for (int l = 0; l < 5; l++) drive_line(320, 192, 251, -1, -1);
    pulse_reset();
    for (int l = 0; l < 2; l++) drive_line(320, 64, 123, -1, -1);
    end_frame();
    chk("t6_mc", max_count, 120);
    chk("t6_det", detected, 0);
    chk("t6_dir", direction, 2);

    repeat (5) @(negedge clk);
    chk("queues_empty", q_m.size() + q_s.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
